// File: rtl/dircc_send_scheduler.sv
// ---------------------------------------------------------------------------
// dircc_send_scheduler
//
// Walks an RTS (ready-to-send) flag mask, lowest port first. For each flagged
// port it looks up how many targets that port has, then issues one header
// request per target to the packet sender. The mask MSB is not a port; it is
// the compute flag, which is latched into compute_pending until acknowledged.
//
// Optional feature: define DIRCC_SEND_SCHED_ABORT_EN to add an 'abort' input
// that cancels the rest of the current mask (SELECT/ISSUE only).
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   rts_valid/mask    new RTS mask offer; rts_accept high only when idle
//   port_query        port whose target count is looked up (SELECT)
//   num_targets       target count for port_query, same cycle
//   issue_valid/ready header request handshake
//   issue_port/target source port and target index of the request
//   busy              FSM not idle
//   done              one-cycle pulse when a mask completes
//   compute_pending   latched compute flag; cleared by compute_ack
//   abort             (DIRCC_SEND_SCHED_ABORT_EN only) cancel current mask
// ---------------------------------------------------------------------------
module dircc_send_scheduler #(
    parameter int RTS_READY_WIDTH    = 32,
    parameter int TARGET_COUNT_WIDTH = 16,
    localparam int PORT_INDEX_WIDTH  = $clog2(RTS_READY_WIDTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rts_valid,
    input  logic [RTS_READY_WIDTH-1:0]    rts_mask,
    output logic                          rts_accept,
    output logic [PORT_INDEX_WIDTH-1:0]   port_query,
    input  logic [TARGET_COUNT_WIDTH-1:0] num_targets,
    output logic                          issue_valid,
    input  logic                          issue_ready,
    output logic [PORT_INDEX_WIDTH-1:0]   issue_port,
    output logic [TARGET_COUNT_WIDTH-1:0] issue_target,
    output logic                          busy,
    output logic                          done,
    output logic                          compute_pending,
    input  logic                          compute_ack
`ifdef DIRCC_SEND_SCHED_ABORT_EN
    ,
    input  logic                          abort
`endif
);

    localparam int MSB = RTS_READY_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        ISSUE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                        state_r;
    logic [RTS_READY_WIDTH-1:0]    pend_r;
    logic [TARGET_COUNT_WIDTH-1:0] cnt_r;
    logic [TARGET_COUNT_WIDTH-1:0] tgt_r;
    logic [PORT_INDEX_WIDTH-1:0]   port_query_r;
    logic [PORT_INDEX_WIDTH-1:0]   issue_port_r;
    logic                          issue_valid_r;
    logic                          done_r;
    logic                          compute_pending_r;

    logic                          hs_s;
    logic                          abort_s;
    logic                          last_beat_s;
    logic [RTS_READY_WIDTH-1:0]    mask_ports_s;
    logic [RTS_READY_WIDTH-1:0]    sel_left_s;
    logic [RTS_READY_WIDTH-1:0]    iss_left_s;

    // Index of the lowest set bit; ties to 0 for an all-zero vector.
    function automatic logic [PORT_INDEX_WIDTH-1:0] lowest_set(
        input logic [RTS_READY_WIDTH-1:0] v
    );
        logic [PORT_INDEX_WIDTH-1:0] idx;
        idx = '0;
        for (int i = RTS_READY_WIDTH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = PORT_INDEX_WIDTH'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Handshake detect, remaining-mask helpers and abort qualification.
    always_comb begin
        hs_s         = rts_valid && (state_r == IDLE);
        mask_ports_s = {1'b0, rts_mask[MSB-1:0]};
        sel_left_s   = pend_r & ~(RTS_READY_WIDTH'(1) << port_query_r);
        iss_left_s   = pend_r & ~(RTS_READY_WIDTH'(1) << issue_port_r);
        last_beat_s  = (tgt_r == (cnt_r - TARGET_COUNT_WIDTH'(1)));
`ifdef DIRCC_SEND_SCHED_ABORT_EN
        if ((state_r == SELECT) || (state_r == ISSUE)) begin
            abort_s = abort;
        end else begin
            abort_s = 1'b0;
        end
`else
        abort_s = 1'b0;
`endif
    end

    // Scheduler FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r           <= IDLE;
            pend_r            <= '0;
            cnt_r             <= '0;
            tgt_r             <= '0;
            port_query_r      <= '0;
            issue_port_r      <= '0;
            issue_valid_r     <= 1'b0;
            done_r            <= 1'b0;
            compute_pending_r <= 1'b0;
        end else begin
            done_r <= 1'b0;

            // A new compute flag beats a simultaneous acknowledge.
            if (hs_s && rts_mask[MSB]) begin
                compute_pending_r <= 1'b1;
            end else if (compute_ack) begin
                compute_pending_r <= 1'b0;
            end else begin
                compute_pending_r <= compute_pending_r;
            end

            case (state_r)
                IDLE: begin
                    if (hs_s) begin
                        pend_r <= mask_ports_s;
                        if (mask_ports_s == '0) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r      <= SELECT;
                            port_query_r <= lowest_set(mask_ports_s);
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SELECT: begin
                    if (abort_s) begin
                        pend_r  <= '0;
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end else begin
                        cnt_r <= num_targets;
                        if (num_targets == '0) begin
                            // Port has nobody to send to: skip it.
                            pend_r <= sel_left_s;
                            if (sel_left_s == '0) begin
                                state_r <= DONE;
                                done_r  <= 1'b1;
                            end else begin
                                port_query_r <= lowest_set(sel_left_s);
                            end
                        end else begin
                            tgt_r         <= '0;
                            issue_port_r  <= port_query_r;
                            issue_valid_r <= 1'b1;
                            state_r       <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (abort_s) begin
                        pend_r        <= '0;
                        issue_valid_r <= 1'b0;
                        state_r       <= DONE;
                        done_r        <= 1'b1;
                    end else if (issue_ready) begin
                        if (last_beat_s) begin
                            pend_r        <= iss_left_s;
                            issue_valid_r <= 1'b0;
                            if (iss_left_s == '0) begin
                                state_r <= DONE;
                                done_r  <= 1'b1;
                            end else begin
                                state_r      <= SELECT;
                                port_query_r <= lowest_set(iss_left_s);
                            end
                        end else begin
                            tgt_r <= tgt_r + TARGET_COUNT_WIDTH'(1);
                        end
                    end else begin
                        state_r <= ISSUE;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r       <= IDLE;
                    issue_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign rts_accept      = (state_r == IDLE);
    assign busy            = (state_r != IDLE);
    assign port_query      = port_query_r;
    assign issue_valid     = issue_valid_r;
    assign issue_port      = issue_port_r;
    assign issue_target    = tgt_r;
    assign done            = done_r;
    assign compute_pending = compute_pending_r;

endmodule

// File: tb/tb_dircc_send_scheduler.sv
module tb_dircc_send_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rts_valid = 1'b0;
    logic [31:0] rts_mask = 32'h0;
    logic        rts_accept;
    logic [4:0]  port_query;
    logic [15:0] num_targets;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    logic [4:0]  issue_port;
    logic [15:0] issue_target;
    logic        busy;
    logic        done;
    logic        compute_pending;
    logic        compute_ack = 1'b0;
`ifdef DIRCC_SEND_SCHED_ABORT_EN
    logic        abort = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Per-port target counts answered combinationally to port_query.
    logic [15:0] tbl [0:31];
    always_comb num_targets = tbl[port_query];

    // Observations from run_mask.
    int          n_iss;
    int          n_done;
    int          done_cyc;
    logic [31:0] iss [0:15];

    always #5 clk = ~clk;

    dircc_send_scheduler dut (
        .clk             (clk),
        .reset           (reset),
        .rts_valid       (rts_valid),
        .rts_mask        (rts_mask),
        .rts_accept      (rts_accept),
        .port_query      (port_query),
        .num_targets     (num_targets),
        .issue_valid     (issue_valid),
        .issue_ready     (issue_ready),
        .issue_port      (issue_port),
        .issue_target    (issue_target),
        .busy            (busy),
        .done            (done),
        .compute_pending (compute_pending),
        .compute_ack     (compute_ack)
`ifdef DIRCC_SEND_SCHED_ABORT_EN
        ,
        .abort           (abort)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one mask, then watch 40 cycles. 'stall' idle cycles precede each accept.
    task automatic run_mask(input logic [31:0] mask, input int stall);
        int          wait_cnt;
        logic [20:0] held;
        n_iss = 0; n_done = 0; done_cyc = -1; wait_cnt = 0; held = '0;
        @(negedge clk);
        check("accept_idle", {31'b0, rts_accept}, 32'h1);
        rts_valid = 1'b1; rts_mask = mask;
        @(negedge clk);
        rts_valid = 1'b0; rts_mask = 32'h0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (issue_valid) begin
                if (wait_cnt > 0) check("stall_stable", {11'b0, issue_port, issue_target}, {11'b0, held});
                held = {issue_port, issue_target};
                if (wait_cnt == stall) begin
                    issue_ready = 1'b1;
                    if (n_iss < 16) iss[n_iss] = {11'b0, issue_port, issue_target};
                    n_iss++;
                    wait_cnt = 0;
                end else begin
                    issue_ready = 1'b0;
                    wait_cnt++;
                end
            end else begin
                issue_ready = (stall == 0);
                wait_cnt = 0;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            @(negedge clk);
        end
        issue_ready = 1'b0;
        check("idle_after", {30'b0, busy, rts_accept}, 32'h1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) tbl[i] = 16'd0;

        // Outputs while reset is held.
        @(negedge clk);
        check("rst_outs", {25'b0, issue_valid, done, busy, compute_pending, rts_accept, issue_port != 5'd0, port_query != 5'd0},
              32'h4);
        check("rst_target", {16'b0, issue_target}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Two ports, ready tied high: (0,0),(0,1),(2,0), done on cycle 6.
        tbl[0] = 16'd2; tbl[2] = 16'd1;
        run_mask(32'h0000_0005, 0);
        check("m5_n_iss", n_iss, 32'd3);
        check("m5_iss0", iss[0], {11'b0, 5'd0, 16'd0});
        check("m5_iss1", iss[1], {11'b0, 5'd0, 16'd1});
        check("m5_iss2", iss[2], {11'b0, 5'd2, 16'd0});
        check("m5_done_cyc", done_cyc, 32'd6);
        check("m5_n_done", n_done, 32'd1);
        check("m5_cp", {31'b0, compute_pending}, 32'h0);

        // Ports 1 (one target) and 4 (two targets).
        tbl[1] = 16'd1; tbl[4] = 16'd2;
        run_mask(32'h0000_0012, 0);
        check("m12_n_iss", n_iss, 32'd3);
        check("m12_iss0", iss[0], {11'b0, 5'd1, 16'd0});
        check("m12_iss1", iss[1], {11'b0, 5'd4, 16'd0});
        check("m12_iss2", iss[2], {11'b0, 5'd4, 16'd1});
        check("m12_done_cyc", done_cyc, 32'd6);

        // Compute flag only: no issues, done the cycle after handshake.
        run_mask(32'h8000_0000, 0);
        check("cp_n_iss", n_iss, 32'd0);
        check("cp_done_cyc", done_cyc, 32'd1);
        check("cp_set", {31'b0, compute_pending}, 32'h1);
        compute_ack = 1'b1;
        @(negedge clk);
        compute_ack = 1'b0;
        check("cp_ack", {31'b0, compute_pending}, 32'h0);

        // Set beats a same-cycle acknowledge.
        rts_valid = 1'b1; rts_mask = 32'h8000_0000; compute_ack = 1'b1;
        @(negedge clk);
        rts_valid = 1'b0; rts_mask = 32'h0; compute_ack = 1'b0;
        check("cp_set_wins", {31'b0, compute_pending}, 32'h1);
        check("cp_done_pulse", {31'b0, done}, 32'h1);
        @(negedge clk);
        compute_ack = 1'b1;
        @(negedge clk);
        compute_ack = 1'b0;
        check("cp_ack2", {31'b0, compute_pending}, 32'h0);

        // Port with zero targets is skipped.
        tbl[1] = 16'd0;
        run_mask(32'h0000_0002, 0);
        check("z_n_iss", n_iss, 32'd0);
        check("z_done_cyc", done_cyc, 32'd2);
        check("z_n_done", n_done, 32'd1);

        // Stalled sender: 4 idle cycles per beat, three accepts.
        tbl[0] = 16'd3;
        run_mask(32'h0000_0001, 4);
        check("st_n_iss", n_iss, 32'd3);
        check("st_iss0", iss[0], {11'b0, 5'd0, 16'd0});
        check("st_iss1", iss[1], {11'b0, 5'd0, 16'd1});
        check("st_iss2", iss[2], {11'b0, 5'd0, 16'd2});
        check("st_done_cyc", done_cyc, 32'd17);

        // Reset during the second issue of a three-target port.
        issue_ready = 1'b1;
        rts_valid = 1'b1; rts_mask = 32'h0000_0001;
        @(negedge clk);
        rts_valid = 1'b0; rts_mask = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check("rs_second_beat", {15'b0, issue_valid, issue_target}, {15'b0, 1'b1, 16'd1});
        reset = 1'b1;
        #1;
        check("rs_drop", {29'b0, issue_valid, busy, done}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        issue_ready = 1'b0;
        n_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (done || issue_valid) n_done++;
            @(negedge clk);
        end
        check("rs_quiet", n_done, 32'd0);
        tbl[0] = 16'd1;
        run_mask(32'h0000_0001, 0);
        check("rs_new_n_iss", n_iss, 32'd1);
        check("rs_new_done_cyc", done_cyc, 32'd3);

`ifdef DIRCC_SEND_SCHED_ABORT_EN
        // Abort while the first beat is accepted: rest of mask dropped.
        tbl[0] = 16'd2; tbl[1] = 16'd2;
        issue_ready = 1'b1;
        rts_valid = 1'b1; rts_mask = 32'h0000_0003;
        @(negedge clk);
        rts_valid = 1'b0; rts_mask = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check("ab_issue", {15'b0, issue_valid, issue_target}, {15'b0, 1'b1, 16'd0});
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_done", {30'b0, done, issue_valid}, 32'h2);
        @(negedge clk);
        check("ab_idle", {30'b0, busy, issue_valid}, 32'h0);
        issue_ready = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
